// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf interface transmit and receive sides.
// Contents:
//   LEAF_* constants: default field widths of the BFT packet and the
//                     default user-port and credit parameters.
//   PKT_* constants:  bit offsets of each packet field.
//   pkt_t:            packed view of one BFT packet.
//   LEAF_CREDIT_*:    width and maximum of a per-port credit counter.
package leaf_pkg;

    localparam int unsigned LEAF_PACKET_BITS           = 49;
    localparam int unsigned LEAF_PAYLOAD_BITS          = 32;
    localparam int unsigned LEAF_NUM_LEAF_BITS         = 5;
    localparam int unsigned LEAF_NUM_PORT_BITS         = 4;
    localparam int unsigned LEAF_NUM_ADDR_BITS         = 7;
    localparam int unsigned LEAF_NUM_OUT_PORTS         = 4;
    localparam int unsigned LEAF_FREESPACE_UPDATE_SIZE = 64;

    // Packet layout: {vld, dst_leaf, dst_port, addr, payload}
    localparam int unsigned PKT_VLD_BIT  = 48;
    localparam int unsigned PKT_LEAF_LSB = 43;
    localparam int unsigned PKT_PORT_LSB = 39;
    localparam int unsigned PKT_ADDR_LSB = 32;

    localparam int unsigned LEAF_CREDIT_BITS = LEAF_NUM_ADDR_BITS + 1;
    localparam int unsigned LEAF_CREDIT_MAX  = 1 << LEAF_NUM_ADDR_BITS;

    typedef struct packed {
        logic                          vld;
        logic [LEAF_NUM_LEAF_BITS-1:0] dst_leaf;
        logic [LEAF_NUM_PORT_BITS-1:0] dst_port;
        logic [LEAF_NUM_ADDR_BITS-1:0] addr;
        logic [LEAF_PAYLOAD_BITS-1:0]  payload;
    } pkt_t;

endpackage

// File: rtl/leaf_packet_tx_rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
// Ports:
//   clk, reset_n  clock and synchronous active-low reset
//   en            arbitration allowed this cycle; grant is all-zero when low
//   req[N]        request per port
//   grant[N]      one-hot grant, combinational from req/en/pointer
// The pointer holds the highest-priority index; after a grant to port j
// it moves to j+1, so the search resumes just after the last winner.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic             found;

    always_comb begin
        grant    = '0;
        found    = 1'b0;
        ptr_next = ptr;
        if (en) begin
            for (int unsigned k = 0; k < N; k++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    if (!found && req[j] && (((32'(ptr) + k) % N) == j)) begin
                        grant[j] = 1'b1;
                        found    = 1'b1;
                        ptr_next = PTR_W'((j + 1) % N);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/leaf_packet_tx.sv
// Transmit half of a leaf interface: takes 32-bit words from the user
// kernel output ports, arbitrates round-robin among ports that are valid,
// configured and hold receiver credit, and registers one BFT packet per
// grant.
// Ports:
//   clk, reset_n              leaf clock, synchronous active-low reset
//   din_leaf_user2interface   packed user words, port 0 in the LSBs
//   vld_user2interface        word valid per port
//   ack_interface2user        one-cycle accept pulse per port (= grant)
//   cfg_vld/port/dst_leaf/dst_port  route table write
//   fs_update_vld/port        credit return of FREESPACE_UPDATE_SIZE
//   bft_ready                 BFT takes the presented packet this cycle
//   resend                    pause: no grants, dout forced to zero
//   dout_leaf_interface2bft   {vld, dst_leaf, dst_port, addr, payload}
module leaf_packet_tx
    import leaf_pkg::*;
#(
    parameter int unsigned PACKET_BITS           = LEAF_PACKET_BITS,
    parameter int unsigned PAYLOAD_BITS          = LEAF_PAYLOAD_BITS,
    parameter int unsigned NUM_LEAF_BITS         = LEAF_NUM_LEAF_BITS,
    parameter int unsigned NUM_PORT_BITS         = LEAF_NUM_PORT_BITS,
    parameter int unsigned NUM_ADDR_BITS         = LEAF_NUM_ADDR_BITS,
    parameter int unsigned NUM_OUT_PORTS         = LEAF_NUM_OUT_PORTS,
    parameter int unsigned FREESPACE_UPDATE_SIZE = LEAF_FREESPACE_UPDATE_SIZE
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]          vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]          ack_interface2user,
    input  logic                              cfg_vld,
    input  logic [NUM_PORT_BITS-1:0]          cfg_port,
    input  logic [NUM_LEAF_BITS-1:0]          cfg_dst_leaf,
    input  logic [NUM_PORT_BITS-1:0]          cfg_dst_port,
    input  logic                              fs_update_vld,
    input  logic [NUM_PORT_BITS-1:0]          fs_update_port,
    input  logic                              bft_ready,
    input  logic                              resend,
    output logic [PACKET_BITS-1:0]            dout_leaf_interface2bft
);

    localparam int unsigned CREDIT_BITS = NUM_ADDR_BITS + 1;
    localparam int unsigned CREDIT_MAX  = 1 << NUM_ADDR_BITS;

    logic [NUM_LEAF_BITS-1:0] route_leaf  [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] route_port  [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] addr_cnt    [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit      [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit_next [NUM_OUT_PORTS];
    logic [NUM_OUT_PORTS-1:0] configured;
    logic [NUM_OUT_PORTS-1:0] eligible;
    logic [NUM_OUT_PORTS-1:0] grant;
    logic [NUM_OUT_PORTS-1:0] cfg_hit;
    logic [NUM_OUT_PORTS-1:0] fs_hit;

    logic                     out_valid;
    logic [PACKET_BITS-2:0]   pkt_body;
    logic                     slot_free;
    logic                     grant_en;
    logic                     any_grant;

    logic [NUM_LEAF_BITS-1:0] sel_leaf;
    logic [NUM_PORT_BITS-1:0] sel_port;
    logic [NUM_ADDR_BITS-1:0] sel_addr;
    logic [PAYLOAD_BITS-1:0]  sel_data;

    assign slot_free = !out_valid || bft_ready;
    assign grant_en  = slot_free && !resend;
    assign any_grant = |grant;

    // Out-of-range cfg/fs port indices match no entry and are dropped.
    always_comb begin
        eligible = '0;
        cfg_hit  = '0;
        fs_hit   = '0;
        for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            eligible[i] = vld_user2interface[i] && configured[i] && (credit[i] != '0);
            cfg_hit[i]  = cfg_vld && (32'(cfg_port) == i);
            fs_hit[i]   = fs_update_vld && (32'(fs_update_port) == i);
        end
    end

    rr_arbiter #(
        .N(NUM_OUT_PORTS)
    ) u_arb (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (grant_en),
        .req    (eligible),
        .grant  (grant)
    );

    assign ack_interface2user = grant;

    always_comb begin
        sel_leaf = '0;
        sel_port = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            if (grant[i]) begin
                sel_leaf = route_leaf[i];
                sel_port = route_port[i];
                sel_addr = addr_cnt[i];
                sel_data = din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    // Net credit change is applied before saturating, so a grant and an
    // update in the same cycle give +FREESPACE_UPDATE_SIZE-1.
    always_comb begin
        int unsigned sum;
        sum = 0;
        for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            sum = 32'(credit[i])
                + (fs_hit[i] ? FREESPACE_UPDATE_SIZE : 32'd0)
                - (grant[i] ? 32'd1 : 32'd0);
            if (sum > CREDIT_MAX) begin
                sum = CREDIT_MAX;
            end
            credit_next[i] = CREDIT_BITS'(sum);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            pkt_body   <= '0;
            configured <= '0;
            for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
                route_leaf[i] <= '0;
                route_port[i] <= '0;
                addr_cnt[i]   <= '0;
                credit[i]     <= CREDIT_BITS'(CREDIT_MAX);
            end
        end else begin
            for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
                if (cfg_hit[i]) begin
                    route_leaf[i] <= cfg_dst_leaf;
                    route_port[i] <= cfg_dst_port;
                    configured[i] <= 1'b1;
                end
                if (grant[i]) begin
                    addr_cnt[i] <= addr_cnt[i] + NUM_ADDR_BITS'(1);
                end
                credit[i] <= credit_next[i];
            end
            // While resend is high or the BFT stalls, the packet is held
            // untouched; a retire without a new grant clears the whole word.
            if (grant_en) begin
                if (any_grant) begin
                    out_valid <= 1'b1;
                    pkt_body  <= {sel_leaf, sel_port, sel_addr, sel_data};
                end else begin
                    out_valid <= 1'b0;
                    pkt_body  <= '0;
                end
            end
        end
    end

    assign dout_leaf_interface2bft = resend ? '0 : {out_valid, pkt_body};

endmodule

// File: tb/tb_leaf_packet_tx.sv
module tb_leaf_packet_tx;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [127:0] din;
    logic [3:0]   vld;
    logic [3:0]   ack;
    logic         cfg_vld;
    logic [3:0]   cfg_port;
    logic [4:0]   cfg_dst_leaf;
    logic [3:0]   cfg_dst_port;
    logic         fs_update_vld;
    logic [3:0]   fs_update_port;
    logic         bft_ready;
    logic         resend;
    logic [48:0]  dout;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    leaf_packet_tx #(
        .NUM_OUT_PORTS(4),
        .FREESPACE_UPDATE_SIZE(64)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .din_leaf_user2interface(din),
        .vld_user2interface     (vld),
        .ack_interface2user     (ack),
        .cfg_vld                (cfg_vld),
        .cfg_port               (cfg_port),
        .cfg_dst_leaf           (cfg_dst_leaf),
        .cfg_dst_port           (cfg_dst_port),
        .fs_update_vld          (fs_update_vld),
        .fs_update_port         (fs_update_port),
        .bft_ready              (bft_ready),
        .resend                 (resend),
        .dout_leaf_interface2bft(dout)
    );

    typedef struct {
        logic         rst;
        logic [3:0]   vld;
        logic [127:0] din;
        logic         cv;
        logic [3:0]   cp;
        logic [4:0]   cl;
        logic [3:0]   cd;
        logic         bft;
        logic         rs;
        logic [3:0]   eack;
        logic [48:0]  edout;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [48:0] pk(input int unsigned leaf, input int unsigned port,
                                       input int unsigned addr, input logic [31:0] d);
        return {1'b1, 5'(leaf), 4'(port), 7'(addr), d};
    endfunction

    function automatic logic [127:0] dw(input logic [31:0] p0, input logic [31:0] p1,
                                        input logic [31:0] p2, input logic [31:0] p3);
        return {p3, p2, p1, p0};
    endfunction

    task automatic add(input logic rst, input logic [3:0] v, input logic [127:0] d,
                       input logic cv, input logic [3:0] cp, input logic [4:0] cl,
                       input logic [3:0] cd, input logic bft, input logic rs,
                       input logic [3:0] eack, input logic [48:0] edout);
        vec_t e;
        e.rst = rst; e.vld = v; e.din = d; e.cv = cv; e.cp = cp; e.cl = cl; e.cd = cd;
        e.bft = bft; e.rs = rs; e.eack = eack; e.edout = edout;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [48:0] got, input logic [48:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge.
    task automatic drive(input logic rst, input logic [3:0] v, input logic [127:0] d,
                         input logic cv, input logic [3:0] cp, input logic [4:0] cl,
                         input logic [3:0] cd, input logic fv, input logic [3:0] fp,
                         input logic bft, input logic rs);
        @(posedge clk);
        #1;
        reset_n = rst; vld = v; din = d;
        cfg_vld = cv; cfg_port = cp; cfg_dst_leaf = cl; cfg_dst_port = cd;
        fs_update_vld = fv; fs_update_port = fp; bft_ready = bft; resend = rs;
    endtask

    initial begin
        logic [48:0] e;
        logic [127:0] z;
        logic [3:0] ea;
        int k;
        int cnt;

        z = '0;
        reset_n = 1'b0; vld = '0; din = '0; cfg_vld = 1'b0; cfg_port = '0;
        cfg_dst_leaf = '0; cfg_dst_port = '0; fs_update_vld = 1'b0;
        fs_update_port = '0; bft_ready = 1'b1; resend = 1'b0;
        repeat (2) @(posedge clk);

        //  rst vld     din                                                        cv cp cl  cd bft rs eack     edout
        add(0, 4'b0000, z,                                                          0, 0, 0,  0, 1, 0, 4'b0000, '0);
        add(1, 4'b0001, dw(32'hDEADBEEF, 0, 0, 0),                                  1, 0, 3,  2, 1, 0, 4'b0000, '0);
        add(1, 4'b0001, dw(32'hDEADBEEF, 0, 0, 0),                                  0, 0, 0,  0, 1, 0, 4'b0001, '0);
        add(1, 4'b0000, z,                                                          0, 0, 0,  0, 1, 0, 4'b0000, pk(3, 2, 0, 32'hDEADBEEF));
        add(1, 4'b0000, z,                                                          1, 1, 1,  1, 1, 0, 4'b0000, '0);
        add(1, 4'b0000, z,                                                          1, 2, 7,  5, 1, 0, 4'b0000, '0);
        add(1, 4'b0000, z,                                                          1, 3, 31, 15, 1, 0, 4'b0000, '0);
        add(1, 4'b0000, z,                                                          1, 4, 9,  9, 1, 0, 4'b0000, '0);
        add(1, 4'b1111, dw(32'h00000001, 32'h10000000, 32'h20000000, 32'h30000000), 0, 0, 0,  0, 1, 0, 4'b0010, '0);
        add(1, 4'b1111, dw(32'h00000001, 32'h10000001, 32'h20000000, 32'h30000000), 0, 0, 0,  0, 1, 0, 4'b0100, pk(1, 1, 0, 32'h10000000));
        add(1, 4'b1111, dw(32'h00000001, 32'h10000001, 32'h20000001, 32'h30000000), 0, 0, 0,  0, 1, 0, 4'b1000, pk(7, 5, 0, 32'h20000000));
        add(1, 4'b1111, dw(32'h00000001, 32'h10000001, 32'h20000001, 32'h30000001), 0, 0, 0,  0, 1, 0, 4'b0001, pk(31, 15, 0, 32'h30000000));
        add(1, 4'b1111, dw(32'h00000002, 32'h10000001, 32'h20000001, 32'h30000001), 0, 0, 0,  0, 1, 0, 4'b0010, pk(3, 2, 1, 32'h00000001));
        add(1, 4'b0000, z,                                                          0, 0, 0,  0, 1, 0, 4'b0000, pk(1, 1, 1, 32'h10000001));
        add(1, 4'b0000, z,                                                          0, 0, 0,  0, 1, 0, 4'b0000, '0);
        add(1, 4'b0100, dw(0, 0, 32'h20000001, 0),                                  0, 0, 0,  0, 1, 0, 4'b0100, '0);
        for (int i = 0; i < 5; i++)
            add(1, 4'b1001, dw(32'h00000002, 0, 0, 32'h30000001),                   0, 0, 0,  0, 0, 0, 4'b0000, pk(7, 5, 1, 32'h20000001));
        add(1, 4'b1001, dw(32'h00000002, 0, 0, 32'h30000001),                       0, 0, 0,  0, 1, 0, 4'b1000, pk(7, 5, 1, 32'h20000001));
        add(1, 4'b0001, dw(32'h00000002, 0, 0, 0),                                  0, 0, 0,  0, 1, 0, 4'b0001, pk(31, 15, 1, 32'h30000001));
        add(1, 4'b0000, z,                                                          0, 0, 0,  0, 1, 0, 4'b0000, pk(3, 2, 2, 32'h00000002));
        add(1, 4'b0010, dw(0, 32'h10000002, 0, 0),                                  0, 0, 0,  0, 1, 0, 4'b0010, '0);
        for (int i = 0; i < 3; i++)
            add(1, 4'b0010, dw(0, 32'h10000003, 0, 0),                              0, 0, 0,  0, 1, 1, 4'b0000, '0);
        add(1, 4'b0010, dw(0, 32'h10000003, 0, 0),                                  0, 0, 0,  0, 1, 0, 4'b0010, pk(1, 1, 2, 32'h10000002));
        add(1, 4'b0000, z,                                                          0, 0, 0,  0, 1, 0, 4'b0000, pk(1, 1, 3, 32'h10000003));
        add(1, 4'b0000, z,                                                          0, 0, 0,  0, 1, 0, 4'b0000, '0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].din, tbl[i].cv, tbl[i].cp, tbl[i].cl,
                  tbl[i].cd, 1'b0, 4'd0, tbl[i].bft, tbl[i].rs);
            @(negedge clk);
            chk($sformatf("v%0d_ack", i), 49'(ack), 49'(tbl[i].eack));
            chk($sformatf("v%0d_dout", i), dout, tbl[i].edout);
        end

        // Reset mid-traffic: vld held, credits partly used.
        drive(0, 4'b1111, dw(32'h1, 32'h2, 32'h3, 32'h4), 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            drive(1, 4'b1111, dw(32'h1, 32'h2, 32'h3, 32'h4), 0, 0, 0, 0, 0, 0, 1, 0);
            @(negedge clk);
            chk($sformatf("post_rst%0d_ack", i), 49'(ack), 49'd0);
            chk($sformatf("post_rst%0d_dout", i), dout, '0);
        end

        // Credit exhaustion on port0 with restored credits.
        drive(1, 4'b0000, z, 1, 0, 4, 3, 0, 0, 1, 0);
        @(negedge clk);
        chk("cfg0_ack", 49'(ack), 49'd0);
        k = 0;
        for (int n = 0; n < 130; n++) begin
            drive(1, 4'b0001, dw(32'hC0DE0000 + 32'(k), 0, 0, 0), 0, 0, 0, 0, 0, 0, 1, 0);
            @(negedge clk);
            ea = (n < 128) ? 4'b0001 : 4'b0000;
            chk($sformatf("exh%0d_ack", n), 49'(ack), 49'(ea));
            if (n == 0 || n == 129) e = '0;
            else e = pk(4, 3, (n - 1) % 128, 32'hC0DE0000 + 32'(n - 1));
            chk($sformatf("exh%0d_dout", n), dout, e);
            if (ack[0]) k++;
        end

        drive(1, 4'b0001, dw(32'hC0DE0000 + 32'(k), 0, 0, 0), 0, 0, 0, 0, 1, 4, 1, 0);
        @(negedge clk);
        chk("fs_oor_ack", 49'(ack), 49'd0);
        drive(1, 4'b0001, dw(32'hC0DE0000 + 32'(k), 0, 0, 0), 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("fs_oor_ack2", 49'(ack), 49'd0);
        drive(1, 4'b0001, dw(32'hC0DE0000 + 32'(k), 0, 0, 0), 0, 0, 0, 0, 1, 0, 1, 0);
        @(negedge clk);
        chk("fs_same_cycle_ack", 49'(ack), 49'd0);
        drive(1, 4'b0001, dw(32'hC0DE0000 + 32'(k), 0, 0, 0), 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("resume_ack", 49'(ack), 49'd1);
        if (ack[0]) k++;
        drive(1, 4'b0001, dw(32'hC0DE0000 + 32'(k), 0, 0, 0), 0, 0, 0, 0, 1, 0, 1, 0);
        @(negedge clk);
        chk("grant_fs_ack", 49'(ack), 49'd1);
        chk("wrap_dout", dout, pk(4, 3, 0, 32'hC0DE0080));
        if (ack[0]) k++;
        drive(1, 4'b0000, z, 0, 0, 0, 0, 1, 0, 1, 0);
        @(negedge clk);
        chk("post_wrap_dout", dout, pk(4, 3, 1, 32'hC0DE0081));

        // 126 + 64 saturates at 128: exactly 128 more words go through.
        cnt = 0;
        for (int n = 0; n < 140; n++) begin
            drive(1, 4'b0001, dw(32'hC0DE0000 + 32'(k), 0, 0, 0), 0, 0, 0, 0, 0, 0, 1, 0);
            @(negedge clk);
            if (ack[0]) begin
                cnt++;
                k++;
            end
        end
        chk("sat_credit_count", 49'(cnt), 49'd128);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
